// File: rtl/vga_pkg.sv
// Shared VGA definitions: resolution, RGB444 pixel type, palette and
// the saturating position-step helper used by the movement controller.
package vga_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t COL_BG     = 12'h00F;
  localparam rgb12_t COL_SPRITE = 12'hF00;
  localparam rgb12_t COL_GRID   = 12'h444;

  typedef enum logic {
    ACCUM,
    APPLY
  } move_state_t;

  // Opposing requests cancel; decrement saturates at 0, increment at lim.
  function automatic logic [10:0] clamp_step(input logic [10:0] p,
                                             input logic        dec,
                                             input logic        inc,
                                             input logic [10:0] step,
                                             input logic [10:0] lim);
    logic [10:0] r;
    r = p;
    if (dec && !inc)
      r = (p < step) ? '0 : p - step;
    else if (inc && !dec)
      r = (p + step > lim) ? lim : p + step;
    return r;
  endfunction

endpackage

// File: rtl/sprite_pos_ctrl.sv
// Sprite movement controller: sticky per-direction pending bits, collected
// over a frame and applied once in the tick cycle with edge clamping.
module sprite_pos_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 32,
  parameter int unsigned STEP     = 4
) (
  input  logic        Master_Clock_In,
  input  logic        Reset_N_In,
  input  logic        Tick_In,
  input  logic        Btn_Up_In,
  input  logic        Btn_Down_In,
  input  logic        Btn_Left_In,
  input  logic        Btn_Right_In,
  output logic [10:0] Pos_X_Out,
  output logic [10:0] Pos_Y_Out
);

  localparam logic [10:0] X_MAX  = 11'(H_RES - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(V_RES - SPRITE_H);
  localparam logic [10:0] X_INIT = 11'((H_RES - SPRITE_W) / 2);
  localparam logic [10:0] Y_INIT = 11'((V_RES - SPRITE_H) / 2);
  localparam logic [10:0] STEP11 = 11'(STEP);

  move_state_t state_q, state_next;
  logic [3:0]  pend_q, pend_next;
  logic [3:0]  btn;
  logic [10:0] x_q, x_next;
  logic [10:0] y_q, y_next;

  assign btn = {Btn_Up_In, Btn_Down_In, Btn_Left_In, Btn_Right_In};

  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      state_q <= ACCUM;
      pend_q  <= '0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
    end else begin
      state_q <= state_next;
      pend_q  <= pend_next;
      x_q     <= x_next;
      y_q     <= y_next;
    end
  end

  // APPLY coincides with the registered frame tick; presses seen during it
  // seed the pending bits for the following frame.
  always_comb begin
    state_next = Tick_In ? APPLY : ACCUM;
    pend_next  = pend_q | btn;
    x_next     = x_q;
    y_next     = y_q;
    if (state_q == APPLY) begin
      pend_next = btn;
      x_next    = clamp_step(x_q, pend_q[1], pend_q[0], STEP11, X_MAX);
      y_next    = clamp_step(y_q, pend_q[3], pend_q[2], STEP11, Y_MAX);
    end
  end

  assign Pos_X_Out = x_q;
  assign Pos_Y_Out = y_q;

endmodule

// File: rtl/vga_sprite_painter.sv
// Two-stage pixel colour pipeline drawing a movable sprite over a background,
// with delay-matched syncs. Optional grid overlay: define SPRITE_GRID_EN.
module vga_sprite_painter
  import vga_pkg::*;
#(
  parameter int unsigned SPRITE_W      = 32,
  parameter int unsigned SPRITE_H      = 32,
  parameter int unsigned STEP          = 4,
  parameter logic [11:0] BG_COLOUR     = COL_BG,
  parameter logic [11:0] SPRITE_COLOUR = COL_SPRITE
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  input  logic       Disp_Ena_In,
  input  logic       Sync_Horiz_In,
  input  logic       Sync_Vert_In,
  input  logic [9:0] Val_Col_In,
  input  logic [9:0] Val_Row_In,
  input  logic       Btn_Up_In,
  input  logic       Btn_Down_In,
  input  logic       Btn_Left_In,
  input  logic       Btn_Right_In,
  output logic [3:0] Red_Out,
  output logic [3:0] Green_Out,
  output logic [3:0] Blue_Out,
  output logic       Sync_Horiz_Out,
  output logic       Sync_Vert_Out,
  output logic [9:0] Sprite_X_Out,
  output logic [9:0] Sprite_Y_Out,
  output logic       Frame_Tick_Out
);

  logic        de1, hs1, vs1;
  logic [9:0]  col1, row1;
  logic        hs2, vs2, tick_q;
  rgb12_t      rgb_q, rgb_next;
  logic        tick_pre, visible, hit;
  logic [10:0] pos_x, pos_y, col11, row11;

  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      de1  <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      col1 <= '0;
      row1 <= '0;
    end else begin
      de1  <= Disp_Ena_In;
      hs1  <= Sync_Horiz_In;
      vs1  <= Sync_Vert_In;
      col1 <= Val_Col_In;
      row1 <= Val_Row_In;
    end
  end

  // vs2 is stage-1 vsync one clock later, so this is its falling edge.
  assign tick_pre = vs2 & ~vs1;

  sprite_pos_ctrl #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .STEP    (STEP)
  ) u_pos (
    .Master_Clock_In(Master_Clock_In),
    .Reset_N_In     (Reset_N_In),
    .Tick_In        (tick_pre),
    .Btn_Up_In      (Btn_Up_In),
    .Btn_Down_In    (Btn_Down_In),
    .Btn_Left_In    (Btn_Left_In),
    .Btn_Right_In   (Btn_Right_In),
    .Pos_X_Out      (pos_x),
    .Pos_Y_Out      (pos_y)
  );

  assign col11   = {1'b0, col1};
  assign row11   = {1'b0, row1};
  assign visible = de1 && (col1 < 10'(H_RES)) && (row1 < 10'(V_RES));
  assign hit     = (col11 >= pos_x) && (col11 < pos_x + 11'(SPRITE_W)) &&
                   (row11 >= pos_y) && (row11 < pos_y + 11'(SPRITE_H));

  always_comb begin
    rgb_next = '0;
    if (visible) begin
      if (hit)
        rgb_next = SPRITE_COLOUR;
`ifdef SPRITE_GRID_EN
      else if ((col1[4:0] == 5'd0) || (row1[4:0] == 5'd0))
        rgb_next = COL_GRID;
`endif
      else
        rgb_next = BG_COLOUR;
    end
  end

  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      rgb_q  <= '0;
      hs2    <= 1'b1;
      vs2    <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_next;
      hs2    <= hs1;
      vs2    <= vs1;
      tick_q <= tick_pre;
    end
  end

  assign Red_Out        = rgb_q.r;
  assign Green_Out      = rgb_q.g;
  assign Blue_Out       = rgb_q.b;
  assign Sync_Horiz_Out = hs2;
  assign Sync_Vert_Out  = vs2;
  assign Frame_Tick_Out = tick_q;
  assign Sprite_X_Out   = pos_x[9:0];
  assign Sprite_Y_Out   = pos_y[9:0];

endmodule

// File: tb/tb_vga_sprite_painter.sv
// Bench for vga_sprite_painter: pixel vectors through a scoreboard queue plus
// frame-level movement sequences, with a second instance at STEP=6.
module tb_vga_sprite_painter;

`ifdef SPRITE_GRID_EN
  localparam bit GRID_ON = 1'b1;
`else
  localparam bit GRID_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de, hs, vs;
  logic [9:0] col, row;
  logic       up, down, left, right;

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, tick_a, hs_b, vs_b, tick_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int checks = 0;
  int errors = 0;

  int mx, my, mx6, my6;
  logic [3:0] carry;

  typedef struct {
    int         c;
    int         r;
    bit         de;
    bit         hs;
    bit         vs;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  always #20 clk = ~clk;

  vga_sprite_painter dut (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Disp_Ena_In(de),
    .Sync_Horiz_In(hs), .Sync_Vert_In(vs), .Val_Col_In(col), .Val_Row_In(row),
    .Btn_Up_In(up), .Btn_Down_In(down), .Btn_Left_In(left), .Btn_Right_In(right),
    .Red_Out(r_a), .Green_Out(g_a), .Blue_Out(b_a),
    .Sync_Horiz_Out(hs_a), .Sync_Vert_Out(vs_a),
    .Sprite_X_Out(x_a), .Sprite_Y_Out(y_a), .Frame_Tick_Out(tick_a)
  );

  vga_sprite_painter #(.STEP(6)) dut6 (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Disp_Ena_In(de),
    .Sync_Horiz_In(hs), .Sync_Vert_In(vs), .Val_Col_In(col), .Val_Row_In(row),
    .Btn_Up_In(up), .Btn_Down_In(down), .Btn_Left_In(left), .Btn_Right_In(right),
    .Red_Out(r_b), .Green_Out(g_b), .Blue_Out(b_b),
    .Sync_Horiz_Out(hs_b), .Sync_Vert_Out(vs_b),
    .Sprite_X_Out(x_b), .Sprite_Y_Out(y_b), .Frame_Tick_Out(tick_b)
  );

  function automatic logic [11:0] bg(input int c, input int r);
    if (GRID_ON && ((c % 32) == 0 || (r % 32) == 0)) return 12'h444;
    return 12'h00F;
  endfunction

  function automatic int mv(input int p, input bit dec, input bit inc,
                            input int step, input int lim);
    if (dec == inc) return p;
    if (dec) return (p - step < 0) ? 0 : p - step;
    return (p + step > lim) ? lim : p + step;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pos(input string name);
    chk({name, "_x"}, 32'(x_a), 32'(mx));
    chk({name, "_y"}, 32'(y_a), 32'(my));
    chk({name, "_x6"}, 32'(x_b), 32'(mx6));
    chk({name, "_y6"}, 32'(y_b), 32'(my6));
  endtask

  // One clock of a pixel with its expected output queued; outputs are
  // compared two edges after the pixel is presented.
  task automatic pix(input int c, input int r, input bit d, input bit h,
                     input bit v, input logic [11:0] e);
    exp_t ex, got;
    de = d; hs = h; vs = v; col = c[9:0]; row = r[9:0];
    up = 0; down = 0; left = 0; right = 0;
    ex.rgb = e; ex.hs = h; ex.vs = v;
    sb.push_back(ex);
    @(posedge clk); #1;
    if (sb.size() >= 2) begin
      got = sb.pop_front();
      checks++;
      if ({r_a, g_a, b_a} !== got.rgb || hs_a !== got.hs || vs_a !== got.vs) begin
        errors++;
        $display("FAIL pixel: got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                 {r_a, g_a, b_a}, hs_a, vs_a, got.rgb, got.hs, got.vs);
      end
    end
  endtask

  task automatic drain();
    pix(700, 500, 0, 1, 1, 12'h000);
    sb.delete();
  endtask

  task automatic drive(input bit v, input logic [3:0] b);
    de = 0; hs = 1; vs = v; col = 10'd700; row = 10'd500;
    {up, down, left, right} = b;
    @(posedge clk); #1;
  endtask

  // mode 0: buttons held through the frame; 1: one-clock pulse mid-frame;
  // 2: buttons only in the APPLY cycle (counts toward the next frame).
  task automatic do_frame(input logic [3:0] b, input int mode);
    logic [3:0] pre, pend;
    pre = (mode == 0) ? b : 4'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, (mode == 1 && i == 3) ? b : pre);
    drive(1'b0, pre);
    chk("tick_early", 32'(tick_a), 32'd0);
    drive(1'b0, pre);
    chk("tick_on", 32'(tick_a), 32'd1);
    chk("tick_vs_align", 32'(vs_a), 32'd0);
    chk_pos("pos_before_update");
    pend  = carry | ((mode == 2) ? 4'b0 : b);
    carry = (mode == 2) ? b : 4'b0;
    mx  = mv(mx,  pend[1], pend[0], 4, 608);
    my  = mv(my,  pend[3], pend[2], 4, 448);
    mx6 = mv(mx6, pend[1], pend[0], 6, 608);
    my6 = mv(my6, pend[3], pend[2], 6, 448);
    drive(1'b0, (mode == 2) ? b : 4'b0);
    chk("tick_off", 32'(tick_a), 32'd0);
    chk_pos("pos_after_update");
    drive(1'b0, 4'b0);
    drive(1'b1, 4'b0);
  endtask

  task automatic model_reset();
    mx = 304; my = 224; mx6 = 304; my6 = 224; carry = 4'b0;
  endtask

  initial begin
    rst_n = 0; de = 0; hs = 1; vs = 1; col = '0; row = '0;
    up = 0; down = 0; left = 0; right = 0;
    model_reset();
    @(posedge clk); #1;
    drive(1'b1, 4'b0);
    chk("reset_rgb", 32'({r_a, g_a, b_a}), 32'h000);
    chk("reset_hs", 32'(hs_a), 32'd1);
    chk("reset_vs", 32'(vs_a), 32'd1);
    chk("reset_tick", 32'(tick_a), 32'd0);
    chk_pos("reset_pos");
    rst_n = 1;
    drive(1'b1, 4'b0);

    vecs.push_back('{304, 224, 1, 1, 1, 12'hF00});
    vecs.push_back('{303, 224, 1, 1, 1, bg(303, 224)});
    vecs.push_back('{335, 255, 1, 1, 1, 12'hF00});
    vecs.push_back('{336, 224, 1, 1, 1, bg(336, 224)});
    vecs.push_back('{304, 256, 1, 1, 1, bg(304, 256)});
    vecs.push_back('{320, 223, 1, 1, 1, bg(320, 223)});
    vecs.push_back('{640, 100, 1, 1, 1, 12'h000});
    vecs.push_back('{100, 480, 1, 1, 1, 12'h000});
    vecs.push_back('{304, 224, 0, 1, 1, 12'h000});
    vecs.push_back('{0,   0,   1, 1, 1, bg(0, 0)});
    vecs.push_back('{32,  10,  1, 1, 1, bg(32, 10)});
    vecs.push_back('{50,  50,  1, 1, 1, 12'h00F});
    vecs.push_back('{700, 10,  0, 0, 1, 12'h000});
    vecs.push_back('{700, 11,  0, 0, 1, 12'h000});
    vecs.push_back('{1000, 1000, 0, 1, 0, 12'h000});
    vecs.push_back('{320, 240, 1, 1, 1, 12'hF00});
    vecs.push_back('{639, 479, 1, 1, 1, bg(639, 479)});
    for (int i = 0; i < vecs.size(); i++)
      pix(vecs[i].c, vecs[i].r, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].rgb);
    drain();
    chk_pos("idle_pos");

    for (int i = 0; i < 3; i++) do_frame(4'b0001, 0);
    chk("right3_x", 32'(x_a), 32'd316);
    do_frame(4'b0010, 1);
    do_frame(4'b0000, 0);
    chk("pulse_left_x", 32'(x_a), 32'd312);
    do_frame(4'b0001, 2);
    do_frame(4'b0000, 0);
    chk("apply_press_x", 32'(x_a), 32'd316);

    for (int i = 0; i < 82; i++) do_frame(4'b1110, 0);
    chk("left_sat_x", 32'(x_a), 32'd0);
    chk("left_sat_x6", 32'(x_b), 32'd0);
    chk("updown_y", 32'(y_a), 32'd224);

    for (int i = 0; i < 100; i++) do_frame(4'b0100, 0);
    chk("down_sat_y", 32'(y_a), 32'd448);
    chk("down_sat_y6", 32'(y_b), 32'd448);
    pix(0,  479, 1, 1, 1, 12'hF00);
    pix(0,  480, 1, 1, 1, 12'h000);
    pix(31, 479, 1, 1, 1, 12'hF00);
    pix(32, 479, 1, 1, 1, bg(32, 479));
    pix(5,  447, 1, 1, 1, 12'h00F);
    pix(5,  448, 1, 1, 1, 12'hF00);
    drain();

    for (int i = 0; i < 125; i++) do_frame(4'b0001, 0);
    chk("right_500_x", 32'(x_a), 32'd500);

    de = 1; hs = 0; vs = 1; col = 10'd520; row = 10'd460;
    {up, down, left, right} = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midframe_rgb", 32'({r_a, g_a, b_a}), 32'hF00);
    chk("midframe_hs", 32'(hs_a), 32'd0);
    rst_n = 0;
    @(posedge clk); #1;
    model_reset();
    chk_pos("midreset_pos");
    chk("midreset_rgb", 32'({r_a, g_a, b_a}), 32'h000);
    chk("midreset_hs", 32'(hs_a), 32'd1);
    chk("midreset_vs", 32'(vs_a), 32'd1);
    chk("midreset_tick", 32'(tick_a), 32'd0);
    rst_n = 1;
    do_frame(4'b0000, 0);
    chk("post_reset_x", 32'(x_a), 32'd304);
    pix(32, 10, 1, 1, 1, bg(32, 10));
    pix(304, 224, 1, 1, 1, 12'hF00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
